// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: default widths, issue FSM states and
// the packed command word stored in the command FIFO.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data0;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is readable combinationally so the
// issue FSM can load and pop it on the same edge.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  cmd_t             push_data_i,
  input  logic             pop_i,
  output cmd_t             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  cmd_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage in front of the combinational alu_top: buffers commands, drives
// registered operands, and holds each result until the consumer takes it.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data0_i,
  input  logic [DATA_W-1:0] cmd_data1_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_data0_o,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [OP_W-1:0]   alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [OP_W-1:0]   res_op_o,
  output logic [CNT_W-1:0]  count_o
);

  state_t            r_state;
  logic [DATA_W-1:0] r_alu_data0;
  logic [DATA_W-1:0] r_alu_data1;
  logic [OP_W-1:0]   r_alu_ctrl;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [OP_W-1:0]   r_res_op;

  cmd_t w_push_cmd;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_pop;

  assign w_push_cmd = '{op: cmd_op_i, data1: cmd_data1_i, data0: cmd_data0_i};

  // Pop exactly when the FSM loads the head: from IDLE, or on a RESP handshake.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == RESP) && res_ready_i));

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (cmd_valid_i),
    .push_data_i(w_push_cmd),
    .pop_i      (w_pop),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (count_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_alu_data0 <= '0;
      r_alu_data1 <= '0;
      r_alu_ctrl  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_alu_data0 <= w_head.data0;
            r_alu_data1 <= w_head.data1;
            r_alu_ctrl  <= w_head.op;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_res_data  <= alu_result_i;
          r_res_op    <= r_alu_ctrl;
          r_res_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            if (!w_empty) begin
              r_alu_data0 <= w_head.data0;
              r_alu_data1 <= w_head.data1;
              r_alu_ctrl  <= w_head.op;
              r_state     <= EXEC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = !w_full;
  assign alu_data0_o = r_alu_data0;
  assign alu_data1_o = r_alu_data1;
  assign alu_ctrl_o  = r_alu_ctrl;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_op_o    = r_res_op;

endmodule
